// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port byte-enable RAM with a registered read.
// Round-robin or fixed priority, locked bursts capped at MAX_BURST beats, per-port read return.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  input  logic                    m0_lock,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic                    m1_lock,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last_grant, w_last_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt, w_cnt_inc;
  logic             r_pend0, r_pend1;
  logic             w_gnt0, w_gnt1, w_cnt_full;

  assign w_cnt_inc  = (r_burst_cnt == CNT_MAX) ? CNT_MAX : r_burst_cnt + CNT_W'(1);
  assign w_cnt_full = (w_cnt_inc == CNT_MAX);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    w_gnt0          = 1'b0;
    w_gnt1          = 1'b0;
    w_state_nxt     = r_state;
    w_last_nxt      = r_last_grant;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        w_burst_cnt_nxt = '0;
        // r_last_grant=1 means port 1 went last, so port 0 wins contention.
        if (m0_req && (!m1_req || (FIXED_PRIO != 0) || r_last_grant)) w_gnt0 = 1'b1;
        else if (m1_req)                                              w_gnt1 = 1'b1;
        if (w_gnt0) begin
          w_last_nxt = 1'b0;
          if (m0_lock) begin
            w_state_nxt     = LOCK0;
            w_burst_cnt_nxt = CNT_W'(1);
          end
        end else if (w_gnt1) begin
          w_last_nxt = 1'b1;
          if (m1_lock) begin
            w_state_nxt     = LOCK1;
            w_burst_cnt_nxt = CNT_W'(1);
          end
        end
      end
      LOCK0: begin
        w_gnt0          = m0_req;
        w_burst_cnt_nxt = w_cnt_inc;
        if (!m0_req || !m0_lock || w_cnt_full) w_state_nxt = IDLE;
      end
      LOCK1: begin
        w_gnt1          = m1_req;
        w_burst_cnt_nxt = w_cnt_inc;
        if (!m1_req || !m1_lock || w_cnt_full) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!reset_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
      r_pend0      <= 1'b0;
      r_pend1      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_pend0      <= w_gnt0 & ~m0_we;
      r_pend1      <= w_gnt1 & ~m1_we;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_pend0 & reset_n;
  assign m1_rvalid = r_pend1 & reset_n;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

  assign ram_we    = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);
  assign ram_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : '0);
  assign ram_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : '0);
  assign ram_be    = w_gnt0 ? m0_be    : (w_gnt1 ? m1_be    : '0);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: round-robin DUT with MAX_BURST=4 on a behavioural RAM, plus a
// fixed-priority DUT sharing the same requester inputs.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_be;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_ram_we;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_ram_wdata;
  logic [9:0]  fp_ram_addr;
  logic [3:0]  fp_ram_be;

  logic [31:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .FIXED_PRIO(0), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  ram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .FIXED_PRIO(1), .MAX_BURST(4)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_lock(m0_lock), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata), .ram_be(fp_ram_be), .ram_we(fp_ram_we),
    .ram_rdata(32'h0)
  );

  // Behavioural single-port RAM: byte-enable write, 1-cycle registered read, preload on reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      mem[16] <= 32'hDEADBEEF;
      mem[32] <= 32'hFFFFFFFF;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [9:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata; m0_be = be;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [9:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata; m1_be = be;
  endtask

  logic g0;
  logic lock_pat [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  logic g0_pat   [10] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    reset_n = 1'b0;
    drive0(1, 0, 0, 10'h010, 32'h0, 4'h0);
    drive1(1, 1, 0, 10'h020, 32'hA5A5A5A5, 4'hF);
    tick();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    tick();

    // Single read on port 0
    reset_n = 1'b1;
    drive0(1, 0, 0, 10'h010, 32'h0, 4'h0);
    drive1(0, 0, 0, 10'h000, 32'h0, 4'h0);
    #1;
    check("rd_m0_gnt", m0_gnt, 1);
    check("rd_m1_gnt", m1_gnt, 0);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_addr, 10'h010);
    tick();
    drive0(0, 0, 0, 10'h000, 32'h0, 4'h0);
    drive1(1, 1, 0, 10'h020, 32'h11223344, 4'b0101);
    #1;
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_rvalid", m1_rvalid, 0);

    // Byte-enable write then read-back on port 1
    check("wr_m1_gnt", m1_gnt, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_be", ram_be, 4'b0101);
    check("wr_ram_wdata", ram_wdata, 32'h11223344);
    tick();
    drive1(1, 0, 0, 10'h020, 32'h0, 4'h0);
    #1;
    check("wr_no_rvalid", m1_rvalid, 0);
    check("rb_m1_gnt", m1_gnt, 1);
    check("rb_ram_be", ram_be, 0);
    tick();
    drive1(0, 0, 0, 10'h000, 32'h0, 4'h0);
    #1;
    check("rb_m1_rvalid", m1_rvalid, 1);
    check("rb_m1_rdata", m1_rdata, 32'hFF22FF44);
    check("rb_m0_rvalid", m0_rvalid, 0);

    // Round-robin contention after a fresh reset; fixed-priority twin watches the same inputs
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    drive0(1, 0, 0, 10'h010, 32'h0, 4'h0);
    drive1(1, 0, 0, 10'h020, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      g0 = ((i % 2) == 0);
      #1;
      check($sformatf("rr_m0_gnt[%0d]", i), m0_gnt, g0);
      check($sformatf("rr_m1_gnt[%0d]", i), m1_gnt, !g0);
      check($sformatf("rr_addr[%0d]", i), ram_addr, g0 ? 10'h010 : 10'h020);
      check($sformatf("fp_m0_gnt[%0d]", i), fp_m0_gnt, 1);
      check($sformatf("fp_m1_gnt[%0d]", i), fp_m1_gnt, 0);
      check($sformatf("fp_addr[%0d]", i), fp_ram_addr, 10'h010);
      tick();
      check($sformatf("rr_m0_rvalid[%0d]", i), m0_rvalid, g0);
      check($sformatf("rr_m1_rvalid[%0d]", i), m1_rvalid, !g0);
      check($sformatf("rr_rdata[%0d]", i), g0 ? m0_rdata : m1_rdata,
            g0 ? 32'hDEADBEEF : 32'hFFFFFFFF);
    end

    // Locked burst on port 0, capped at four beats while port 1 keeps requesting
    for (int i = 0; i < 10; i++) begin
      m0_lock = lock_pat[i];
      #1;
      check($sformatf("lk_m0_gnt[%0d]", i), m0_gnt, g0_pat[i]);
      check($sformatf("lk_m1_gnt[%0d]", i), m1_gnt, !g0_pat[i]);
      tick();
      check($sformatf("lk_m0_rvalid[%0d]", i), m0_rvalid, g0_pat[i]);
    end

    // Release by an unlocked beat: waiting port 1 is granted only the following cycle
    drive0(1, 0, 1, 10'h010, 32'h0, 4'h0);
    drive1(0, 0, 0, 10'h020, 32'h0, 4'h0);
    #1;
    check("rel_lock_gnt", m0_gnt, 1);
    tick();
    m0_lock = 1'b0;
    m1_req  = 1'b1;
    #1;
    check("rel_last_m0_gnt", m0_gnt, 1);
    check("rel_last_m1_gnt", m1_gnt, 0);
    tick();
    m0_req = 1'b0;
    #1;
    check("rel_next_m1_gnt", m1_gnt, 1);
    tick();

    // Reset right after a granted read: no rvalid, and port 0 wins the first contention
    drive0(1, 0, 0, 10'h010, 32'h0, 4'h0);
    drive1(0, 0, 0, 10'h020, 32'h0, 4'h0);
    #1;
    check("rm_m0_gnt", m0_gnt, 1);
    tick();
    reset_n = 1'b0;
    m0_req  = 1'b0;
    #1;
    check("rm_rvalid_in_rst", m0_rvalid, 0);
    tick();
    tick();
    reset_n = 1'b1;
    drive0(1, 0, 0, 10'h010, 32'h0, 4'h0);
    drive1(1, 0, 0, 10'h020, 32'h0, 4'h0);
    #1;
    check("rm_rvalid_after", m0_rvalid, 0);
    check("rm_first_m0_gnt", m0_gnt, 1);
    check("rm_first_m1_gnt", m1_gnt, 0);
    tick();
    drive0(0, 0, 0, 10'h000, 32'h0, 4'h0);
    drive1(0, 0, 0, 10'h000, 32'h0, 4'h0);
    #1;
    check("rm_m0_rvalid", m0_rvalid, 1);
    check("rm_m0_rdata", m0_rdata, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port, byte-enable on-chip RAM between two requesters: port 0 (e.g. the pixel fetch side) and port 1 (e.g. the CPU/config side).
- Grants at most one access per cycle, using round-robin or fixed priority.
- Supports locked bursts so a requester can hold the RAM for consecutive beats.
- Returns read data with a per-port valid strobe, matched to the RAM's 1-cycle registered read.

Parameters:
ADDR_WIDTH, 10, RAM word-address width
DATA_WIDTH, 32, data width; multiple of 8
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins when not locked
MAX_BURST, 16, max consecutive cycles one port may hold a lock; must be at least 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
m0_req  in  1  port 0 access request
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  ADDR_WIDTH  port 0 word address
m0_wdata  in  DATA_WIDTH  port 0 write data
m0_be  in  DATA_WIDTH/8  port 0 byte enables (writes only)
m0_lock  in  1  port 0 requests to keep the grant next cycle
m0_gnt  out  1  port 0 access accepted this cycle
m0_rvalid  out  1  port 0 read data valid
m0_rdata  out  DATA_WIDTH  port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_lock, m1_gnt, m1_rvalid, m1_rdata  (as port 0, for port 1)
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_wdata  out  DATA_WIDTH  to RAM wdata
ram_be  out  DATA_WIDTH/8  to RAM byte enables
ram_we  out  1  to RAM write enable
ram_rdata  in  DATA_WIDTH  from RAM; registered, valid 1 cycle after a read

Behaviour:
- Handshake:
  - An access completes in any cycle where mX_req=1 and mX_gnt=1.
  - mX_gnt is combinational from req and state, same cycle.
  - The requester holds its request fields stable until granted.
- RAM drive:
  - ram_* signals are combinationally muxed from the granted port.
  - ram_we = gnt & we; ram_be = granted port's be.
  - With no grant: ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0.
- Read return:
  - A granted read (we=0) sets a 1-bit per-port pending flag.
  - Next cycle, mX_rvalid=1 and mX_rdata=ram_rdata.
  - Reads are fully pipelined: one read per cycle gives rvalid every cycle.
  - Writes never produce rvalid.
  - mX_rdata = ram_rdata at all times; only meaningful while rvalid=1.
- States:
  - IDLE:
    - Only one port requesting: grant it.
    - Both requesting, FIXED_PRIO=1: grant port 0.
    - Both requesting, FIXED_PRIO=0: grant the port not in last_grant.
    - On any grant, last_grant <= granted port.
    - A granted beat with lock=1 goes to LOCK0 or LOCK1 and sets burst_cnt <= 1.
  - LOCKx:
    - Only port x may be granted; the other port's gnt=0 regardless of its req.
    - burst_cnt increments every cycle spent in LOCKx.
    - Return to IDLE when any of these holds:
      - an accepted beat has lock=0;
      - mX_req=0 (requester abandoned the lock);
      - burst_cnt reaches MAX_BURST (forced release; this cycle's beat is still granted if requested).
    - last_grant stays x, so under round-robin the other port wins the next contention.
- Simultaneous events:
  - In LOCKx, a release condition and a new req on the other port in the same cycle: the other port is not granted until the following cycle (no combinational bypass).
- Reset (reset_n=0 at a clock edge):
  - State IDLE, last_grant=1 (port 0 wins first contention), burst_cnt=0, both pending flags cleared.
  - While reset_n=0: m0_gnt=m1_gnt=0, rvalid=0, all ram_* signals 0.
  - A read granted in the cycle before reset produces no rvalid.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST.

Test Plan:
- Single read: m0 read addr 0x010, RAM preloaded 0xDEADBEEF -> m0_gnt same cycle, ram_we=0, next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; no m1_rvalid.
- Byte-enable write then read: m1 writes 0x11223344 be=4'b0101 to 0x020 holding 0xFFFFFFFF -> m1 reads back 0xFF22FF44, rvalid exactly 1 cycle after grant.
- Round-robin contention: both ports request reads every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each rvalid lands on the right port only, 1 cycle later.
- Fixed priority, FIXED_PRIO=1, both requesting continuously -> port 0 granted every cycle, m1_gnt stays 0.
- Lock burst, MAX_BURST=4: m0 holds lock=1 and requests 10 cycles while m1 requests -> m0 granted 4 consecutive cycles, then m1 granted next cycle, then alternation resumes.
- Reset mid-read: grant an m0 read, pull reset_n low the next edge -> m0_rvalid stays 0; after release, the first contention grants port 0.
